// File: rtl/ps2_keymem.sv
// PS/2 keyboard receiver with a scan-code FIFO exposed as a small
// memory-mapped peripheral (DATA and STATUS words at 0x003xxxxx).
module ps2_keymem #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] rdaddr,
    input  logic        rden,
    output logic [31:0] dataout,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
    logic fall;

    rx_state_t       state, state_nx;
    logic [2:0]      bitcnt, bitcnt_nx;
    logic [7:0]      shreg, shreg_nx;
    logic            parbit, parbit_nx;
    logic [TO_W-1:0] tocnt, tocnt_nx;
    logic            timeout, frame_good, frame_bad;

    logic            vld_p1;
    logic [7:0]      byte_p1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nx;
    logic             full, push, pop;
    logic             overflow, frame_err, ovf_set;
    logic             sel, rd_data, rd_stat;
    logic [5:0]       cnt6;
    logic             unused_addr;

    assign unused_addr = ^{rdaddr[19:4], rdaddr[1:0]};

    // Synchronise the PS/2 lines; idle bus level is high
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    // Receiver next-state logic: sample only on a synced falling edge
    always_comb begin
        state_nx   = state;
        bitcnt_nx  = bitcnt;
        shreg_nx   = shreg;
        parbit_nx  = parbit;
        tocnt_nx   = tocnt;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        timeout    = (state != IDLE) && (tocnt == TO_W'(TIMEOUT_CYCLES));

        if (state == IDLE || fall) tocnt_nx = '0;
        else                       tocnt_nx = tocnt + TO_W'(1);

        if (timeout) begin
            state_nx  = IDLE;
            tocnt_nx  = '0;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nx  = DATA;
                        bitcnt_nx = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nx  = {dat_s2, shreg[7:1]};
                    bitcnt_nx = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
                    parbit_nx = dat_s2;
                    state_nx  = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    // stop bit high and odd parity over data+parity
                    if (dat_s2 && (^{shreg, parbit})) frame_good = 1'b1;
                    else                               frame_bad  = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Receiver state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            parbit <= 1'b0;
            tocnt  <= '0;
        end else begin
            state  <= state_nx;
            bitcnt <= bitcnt_nx;
            shreg  <= shreg_nx;
            parbit <= parbit_nx;
            tocnt  <= tocnt_nx;
        end
    end

    // ---- stage p1: completed good byte waits one cycle for the FIFO write ----
    // Valid flag for the pending byte
    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= frame_good;
    end

    // Pending byte payload
    always_ff @(posedge clock) begin
        byte_p1 <= shreg;
    end

    // Read decode and FIFO handshakes
    assign sel     = rden && (rdaddr[31:20] == 12'h003);
    assign rd_data = sel && (rdaddr[3:2] == 2'd0);
    assign rd_stat = sel && (rdaddr[3:2] == 2'd1);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = rd_data && (count != '0);
    assign push    = vld_p1 && (!full || pop);
    assign ovf_set = vld_p1 && full && !pop;
    assign cnt6    = 6'(count);

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + CNT_W'(1);
            2'b01:   count_nx = count - CNT_W'(1);
            default: count_nx = count;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= byte_p1;
    end

    // FIFO pointers, count, sticky flags and interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nx;
            overflow  <= ovf_set   | (overflow  & ~rd_stat);
            frame_err <= frame_bad | (frame_err & ~rd_stat);
            irq       <= (count_nx != '0);
        end
    end

    // Registered read data; untouched when the address is not ours
    always_ff @(posedge clock) begin
        if (reset) begin
            dataout <= '0;
        end else if (sel) begin
            case (rdaddr[3:2])
                2'd0:    dataout <= pop ? {23'b0, 1'b1, mem[rd_ptr]} : 32'h0;
                2'd1:    dataout <= {24'b0, cnt6, frame_err, overflow};
                default: dataout <= 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keymem.sv
// Self-checking bench for ps2_keymem: table of frame/read records plus
// hand-written sequences for overflow, timeout, push/pop collision and reset.
module tb_ps2_keymem;
    localparam int DEPTH = 16;
    localparam int TMO   = 200;
    localparam int HALF  = 8;
    localparam logic [31:0] A_DATA  = 32'h0030_0000;
    localparam logic [31:0] A_STAT  = 32'h0030_0004;
    localparam logic [31:0] A_RSV   = 32'h0030_0008;
    localparam logic [31:0] A_OTHER = 32'h0040_0004;

    logic        clock = 1'b0;
    logic        reset, ps2_clk, ps2_data, rden, irq;
    logic [31:0] rdaddr, dataout;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [31:0] exp; int tag; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          send;
        logic [7:0]  b;
        bit          flip;
        bit          exp_irq;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[11];

    always #5 clock = ~clock;

    ps2_keymem #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rdaddr   (rdaddr),
        .rden     (rden),
        .dataout  (dataout),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // issue a read (rden left high so callers can chain back-to-back reads)
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input int tag);
        sb_t e;
        rden   = 1'b1;
        rdaddr = addr;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
        @(negedge clock);
        e = sb_q.pop_front();
        check($sformatf("read%0d", e.tag), dataout, e.exp);
    endtask

    task automatic rd_one(input logic [31:0] addr, input logic [31:0] exp, input int tag);
        rd(addr, exp, tag);
        rden = 1'b0;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip);
        logic par;
        par = ~(^b) ^ flip;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_n(input logic [10:0] f, input int from, input int to);
        for (int i = from; i < to; i++) ps2_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit flip);
        send_n(mk_frame(b, flip), 0, 11);
        repeat (20) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] f;

        vt[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, A_DATA,  32'h0000_011C};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, A_STAT,  32'h0000_0000};
        vt[2]  = '{1'b1, 8'h1C, 1'b1, 1'b0, A_STAT,  32'h0000_0002};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, A_STAT,  32'h0000_0000};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, A_DATA,  32'h0000_0000};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, A_RSV,   32'h0000_0000};
        vt[6]  = '{1'b1, 8'hA5, 1'b0, 1'b1, A_STAT,  32'h0000_0004};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, A_OTHER, 32'h0000_0004};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, A_DATA,  32'h0000_01A5};
        vt[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, A_DATA,  32'h0000_01FF};
        vt[10] = '{1'b1, 8'h00, 1'b0, 1'b1, A_DATA,  32'h0000_0100};

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rden = 1'b0; rdaddr = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_dataout", dataout, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (vt[i].send) send_byte(vt[i].b, vt[i].flip);
            check($sformatf("irq_vec%0d", i), 32'(irq), 32'(vt[i].exp_irq));
            rd_one(vt[i].addr, vt[i].exp, i);
        end

        // 17 frames into a 16-deep FIFO, then drain back-to-back
        for (int b = 1; b <= 17; b++) send_byte(8'(b), 1'b0);
        check("irq_full", 32'(irq), 32'h1);
        rd_one(A_STAT, 32'h0000_0041, 100);
        for (int i = 0; i < 16; i++) rd(A_DATA, 32'h101 + 32'(i), 101 + i);
        rden = 1'b0;
        rd_one(A_STAT, 32'h0, 120);
        check("irq_drained", 32'(irq), 32'h0);

        // partial frame abandoned by the timeout
        f = mk_frame(8'h00, 1'b0);
        send_n(f, 0, 4);
        repeat (TMO + 50) @(negedge clock);
        check("irq_timeout", 32'(irq), 32'h0);
        rd_one(A_STAT, 32'h0000_0002, 200);
        send_byte(8'hF0, 1'b0);
        rd_one(A_DATA, 32'h0000_01F0, 201);

        // new byte lands in the same cycle as a DATA pop
        send_byte(8'h33, 1'b0);
        f = mk_frame(8'h44, 1'b0);
        send_n(f, 0, 10);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        rd_one(A_DATA, 32'h0000_0133, 250);
        repeat (HALF - 1) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clock);
        rd_one(A_STAT, 32'h0000_0004, 251);
        rd_one(A_DATA, 32'h0000_0144, 252);

        // reset mid-frame together with a DATA read
        send_byte(8'h5A, 1'b0);
        rd_one(A_STAT, 32'h0000_0004, 300);
        f = mk_frame(8'hE1, 1'b0);
        send_n(f, 0, 6);
        reset = 1'b1; rden = 1'b1; rdaddr = A_DATA;
        @(negedge clock);
        reset = 1'b0; rden = 1'b0;
        check("rst_rden_dataout", dataout, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        send_n(f, 6, 11);
        repeat (20) @(negedge clock);
        check("irq_after_tail", 32'(irq), 32'h0);
        rd_one(A_STAT, 32'h0, 301);
        rd_one(A_DATA, 32'h0, 302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
